input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce_pkg.sv | 11 +
 rtl/input_debounce_chan.sv | 78 +++++++
 rtl/input_debounce.sv | 69 ++++++
 tb/tb_input_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
// Shared types and constants for the input_debounce block.
package input_debounce_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/input_debounce_chan.sv
// One debounce channel: stability FSM, persistence counter, level and edge pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   STABLE   | i_in matches o_level, counter held at 0
//   COUNTING | i_in differs from o_level, counter = cycles it has differed
module debounce_chan
    import input_debounce_pkg::*;
#(
    parameter int   CNT_W   = DEFAULT_CNT_W,
    parameter logic DEFAULT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall
);

    deb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] w_thr_eff;

    // A zero threshold behaves as one so a change is never accepted on the
    // same edge that first sees it.
    assign w_thr_eff = (i_thresh == '0) ? CNT_W'(1) : i_thresh;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= DEFAULT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE: begin
                    if (i_in != r_level) begin
                        r_state <= COUNTING;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                COUNTING: begin
                    if (i_in == r_level) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= w_thr_eff) begin
                        r_level <= i_in;
                        r_rise  <= i_in;
                        r_fall  <= ~i_in;
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else begin
                        // Cannot wrap: commit happens at the threshold, which
                        // is bounded by the counter's full-scale value.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input debouncer with a shared persistence threshold.
// Optional sticky event/interrupt latch is built when DEBOUNCE_IRQ_EN is defined.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               CNT_W   = DEFAULT_CNT_W,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic [CNT_W-1:0] i_thresh,
`ifdef DEBOUNCE_IRQ_EN
    input  logic [WIDTH-1:0] i_irq_clr,
    output logic [WIDTH-1:0] o_irq_pending,
    output logic             o_irq,
`endif
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_chan #(
            .CNT_W   (CNT_W),
            .DEFAULT (DEFAULT[g])
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_in     (i_in[g]),
            .i_thresh (i_thresh),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign o_level = w_level;
    assign o_rise  = w_rise;
    assign o_fall  = w_fall;

`ifdef DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] r_irq_pending;
    logic             r_irq;
    logic [WIDTH-1:0] w_pending_nxt;

    // A new event outranks a clear arriving in the same cycle.
    assign w_pending_nxt = (r_irq_pending & ~i_irq_clr) | w_rise | w_fall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_irq_pending <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_irq_pending <= w_pending_nxt;
            r_irq         <= |w_pending_nxt;
        end
    end

    assign o_irq_pending = r_irq_pending;
    assign o_irq         = r_irq;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: per-cycle model compare plus literal checks.
module tb_input_debounce;

    localparam int         WIDTH = 2;
    localparam int         CNT_W = 16;
    localparam logic [1:0] DEF   = 2'b10;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_v;
    logic [CNT_W-1:0] thr;
    logic [WIDTH-1:0] level, rise, fall;
`ifdef DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pend;
    logic             irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    input_debounce #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .DEFAULT (DEF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in          (in_v),
        .i_thresh      (thr),
`ifdef DEBOUNCE_IRQ_EN
        .i_irq_clr     (clr),
        .o_irq_pending (pend),
        .o_irq         (irq),
`endif
        .o_level       (level),
        .o_rise        (rise),
        .o_fall        (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a channel accepts a new level once the edge index has advanced
    // max(thr,1) edges past the edge where the mismatch was first seen.
    logic [1:0]  m_level = DEF;
    logic [1:0]  m_rise  = '0;
    logic [1:0]  m_fall  = '0;
    logic [1:0]  m_pend  = '0;
    bit          m_run [2];
    int unsigned m_start [2];
    int unsigned edge_n = 0;

    initial begin
        int unsigned eff;
        m_run[0] = 0;
        m_run[1] = 0;
        forever begin
            @(posedge clk);
            eff = (thr == 0) ? 1 : int'(thr);
`ifdef DEBOUNCE_IRQ_EN
            m_pend = !rst_n ? 2'b00 : ((m_pend & ~clr) | m_rise | m_fall);
`endif
            for (int i = 0; i < WIDTH; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (!rst_n) begin
                    m_level[i] = DEF[i];
                    m_run[i]   = 0;
                end else if (in_v[i] != m_level[i]) begin
                    if (!m_run[i]) begin
                        m_run[i]   = 1;
                        m_start[i] = edge_n;
                    end else if (edge_n - m_start[i] >= eff) begin
                        m_level[i] = in_v[i];
                        m_rise[i]  = in_v[i];
                        m_fall[i]  = ~in_v[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            edge_n++;
            #1;
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_rise",  32'(rise),  32'(m_rise));
            chk("model_fall",  32'(fall),  32'(m_fall));
`ifdef DEBOUNCE_IRQ_EN
            chk("model_pend",  32'(pend),  32'(m_pend));
            chk("model_irq",   32'(irq),   32'(|m_pend));
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_v  = 2'b10;
        thr   = 16'd4;
`ifdef DEBOUNCE_IRQ_EN
        clr   = 2'b00;
`endif
        tick(3);
        chk("reset_level", 32'(level), 32'(2'b10));
        chk("reset_rise",  32'(rise),  32'(2'b00));
        chk("reset_fall",  32'(fall),  32'(2'b00));
        rst_n = 1'b1;
        tick(2);

        // glitch shorter than the threshold is ignored
        in_v = 2'b11;
        tick(3);
        in_v = 2'b10;
        tick(3);
        chk("glitch_level", 32'(level), 32'(2'b10));

        // accepted rise after four edges
        in_v = 2'b11;
        tick(4);
        chk("rise_pre_level", 32'(level), 32'(2'b10));
        tick(1);
        chk("rise_level", 32'(level), 32'(2'b11));
        chk("rise_pulse", 32'(rise),  32'(2'b01));
        tick(1);
        chk("rise_pulse_end", 32'(rise), 32'(2'b00));

        // zero threshold: one edge of latency
        thr  = 16'd0;
        in_v = 2'b10;
        tick(1);
        chk("thr0_pre", 32'(level), 32'(2'b11));
        tick(1);
        chk("thr0_level", 32'(level), 32'(2'b10));
        chk("thr0_fall",  32'(fall),  32'(2'b01));

        // simultaneous commits on both channels
        in_v = 2'b01;
        tick(2);
        chk("both_level", 32'(level), 32'(2'b01));
        chk("both_rise",  32'(rise),  32'(2'b01));
        chk("both_fall",  32'(fall),  32'(2'b10));
        in_v = 2'b10;
        tick(3);

        // threshold lowered mid-count commits on the next edge
        thr  = 16'd10;
        in_v = 2'b11;
        tick(6);
        chk("lower_pre", 32'(level), 32'(2'b10));
        thr = 16'd5;
        tick(1);
        chk("lower_level", 32'(level), 32'(2'b11));
        chk("lower_rise",  32'(rise),  32'(2'b01));

        // reset mid-count discards the partial count
        thr  = 16'd4;
        in_v = 2'b01;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("rst_mid_level", 32'(level), 32'(2'b10));
        chk("rst_mid_fall",  32'(fall),  32'(2'b00));
        tick(1);
        rst_n = 1'b1;
        tick(4);
        chk("restart_pre", 32'(level), 32'(2'b10));
        tick(1);
        chk("restart_level", 32'(level), 32'(2'b01));
        chk("restart_fall",  32'(fall),  32'(2'b10));
        tick(2);

        // interrupt latch: set beats clear, then a later clear wins
        thr  = 16'd0;
        in_v = 2'b00;
        tick(3);
`ifdef DEBOUNCE_IRQ_EN
        clr = 2'b11;
        tick(1);
        clr = 2'b00;
        chk("irq_cleared", 32'(pend), 32'(2'b00));
        chk("irq_low",     32'(irq),  32'(1'b0));
`endif
        in_v = 2'b01;
        tick(2);
        chk("irq_rise", 32'(rise), 32'(2'b01));
`ifdef DEBOUNCE_IRQ_EN
        clr = 2'b01;
        tick(1);
        chk("irq_set_wins", 32'(pend), 32'(2'b01));
        chk("irq_high",     32'(irq),  32'(1'b1));
        tick(1);
        clr = 2'b00;
        chk("irq_clr_later", 32'(pend), 32'(2'b00));
        chk("irq_drop",      32'(irq),  32'(1'b0));
`endif
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
